// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD serial adder: digit width, state
// encoding and a digit-extraction helper.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // 2'd3 is unused and steered back to ST_IDLE by the sequencer.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Callers zero-extend their operand to 32 bits (eight digits at most).
    function automatic logic [DIGIT_W-1:0] get_digit(input logic [31:0] vec,
                                                     input logic [2:0]  i);
        return vec[{i, 2'b00} +: DIGIT_W];
    endfunction

endpackage

// File: rtl/Single_Digit_Decimal_Adder.sv
// One-digit decimal adder: a + b + cin with the result corrected back into 0..9
// and a decimal carry out.
module Single_Digit_Decimal_Adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] bin_sum;

    assign bin_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign cout    = (bin_sum > 5'd9);
    // Adding 6 skips the six unused codes so the low nibble wraps to 0..9.
    assign s       = cout ? 4'(bin_sum + 5'd6) : bin_sum[3:0];

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder: one decimal digit per clock through a single
// shared digit adder. Define BCD_SERIAL_INPUT_CHECK_EN to add the err output.
module bcd_serial_adder_ctrl
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] a_bcd,
    input  logic [4*NUM_DIGITS-1:0] b_bcd,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] sum_bcd,
    output logic                    cout
`ifdef BCD_SERIAL_INPUT_CHECK_EN
    ,
    output logic                    err
`endif
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic                    carry_reg;
    logic [4*NUM_DIGITS-1:0] a_reg, b_reg;
    logic                    cout_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    accept;
    logic                    add_en;

    logic [DIGIT_W-1:0]      adder_a, adder_b, adder_s;
    logic                    adder_cout;

    assign add_en  = (state_reg == ST_ADD);
    assign adder_a = get_digit(32'(a_reg), 3'(idx_reg));
    assign adder_b = get_digit(32'(b_reg), 3'(idx_reg));

    Single_Digit_Decimal_Adder u_digit_adder (
        .a    (adder_a),
        .b    (adder_b),
        .cin  (carry_reg),
        .s    (adder_s),
        .cout (adder_cout)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_ADD;
                    idx_next   = '0;
                end
            end
            ST_ADD: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = ST_DONE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            // busy/done are decoded from the next state so they line up with it.
            busy_reg  <= (state_next == ST_ADD);
            done_reg  <= (state_next == ST_DONE);
            if (accept) begin
                a_reg     <= a_bcd;
                b_reg     <= b_bcd;
                carry_reg <= cin;
                cout_reg  <= 1'b0;
            end else if (add_en) begin
                carry_reg <= adder_cout;
                if (idx_reg == LAST_IDX) begin
                    cout_reg <= adder_cout;
                end
            end
        end
    end

    // Each result digit owns its register and loads only on its own index.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sum_digit
        logic [DIGIT_W-1:0] digit_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                digit_reg <= '0;
            end else if (accept) begin
                digit_reg <= '0;
            end else if (add_en && (idx_reg == IDX_W'(gi))) begin
                digit_reg <= adder_s;
            end
        end

        assign sum_bcd[gi*DIGIT_W +: DIGIT_W] = digit_reg;
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign cout = cout_reg;

`ifdef BCD_SERIAL_INPUT_CHECK_EN
    logic [NUM_DIGITS-1:0] bad_digit;
    logic                  err_reg;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_check
        assign bad_digit[gi] = (a_bcd[gi*DIGIT_W +: DIGIT_W] > BCD_MAX) ||
                               (b_bcd[gi*DIGIT_W +: DIGIT_W] > BCD_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (accept) begin
            err_reg <= |bad_digit;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for bcd_serial_adder_ctrl: a 4-digit instance for the main
// sequences and a 1-digit instance for the single-digit corner.
module tb_bcd_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a_bcd, b_bcd;
    logic        cin;
    logic        busy, done, cout;
    logic [15:0] sum_bcd;

    logic        start1;
    logic [3:0]  a1, b1;
    logic        cin1;
    logic        busy1, done1, cout1;
    logic [3:0]  sum1;

`ifdef BCD_SERIAL_INPUT_CHECK_EN
    logic        err, err1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_serial_adder_ctrl #(.NUM_DIGITS(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_bcd   (a_bcd),
        .b_bcd   (b_bcd),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum_bcd (sum_bcd),
        .cout    (cout)
`ifdef BCD_SERIAL_INPUT_CHECK_EN
        ,
        .err     (err)
`endif
    );

    bcd_serial_adder_ctrl #(.NUM_DIGITS(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start1),
        .a_bcd   (a1),
        .b_bcd   (b1),
        .cin     (cin1),
        .busy    (busy1),
        .done    (done1),
        .sum_bcd (sum1),
        .cout    (cout1)
`ifdef BCD_SERIAL_INPUT_CHECK_EN
        ,
        .err     (err1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One start pulse, then watch busy/done timing and the held result.
    task automatic run_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                           input logic [15:0] exp_sum, input logic exp_cout, input string tag);
        int busy_cnt;
        int done_k;
        @(negedge clk);
        a_bcd = a;
        b_bcd = b;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        done_k   = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
        end
        check({tag, " busy_cycles"}, busy_cnt, 4);
        check({tag, " done_cycle"}, done_k, 5);
        check({tag, " sum"}, {16'h0, sum_bcd}, {16'h0, exp_sum});
        check({tag, " cout"}, {31'h0, cout}, {31'h0, exp_cout});
        @(negedge clk);
        check({tag, " done_pulse_end"}, {31'h0, done}, 0);
        check({tag, " sum_held"}, {16'h0, sum_bcd}, {16'h0, exp_sum});
        $display("add %h + %h + %0d -> sum %h cout %0d", a, b, c, sum_bcd, cout);
    endtask

    initial begin
        int done_cnt;
        int first_k;
        int second_k;
        int done_k;

        rst    = 1'b1;
        start  = 1'b0;
        a_bcd  = 16'h0;
        b_bcd  = 16'h0;
        cin    = 1'b0;
        start1 = 1'b0;
        a1     = 4'h0;
        b1     = 4'h0;
        cin1   = 1'b0;
        #1;
        check("reset busy", {31'h0, busy}, 0);
        check("reset done", {31'h0, done}, 0);
        check("reset sum", {16'h0, sum_bcd}, 0);
        check("reset cout", {31'h0, cout}, 0);
`ifdef BCD_SERIAL_INPUT_CHECK_EN
        check("reset err", {31'h0, err}, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_add(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, "add_1234_5678");
        run_add(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, "ripple_9999_0001");
        run_add(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, "max_9999_9999_c1");

        // start held high: accepted only in IDLE, operands ignored while busy
        @(negedge clk);
        a_bcd = 16'h0005;
        b_bcd = 16'h0004;
        cin   = 1'b0;
        start = 1'b1;
        done_cnt = 0;
        first_k  = 0;
        second_k = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a_bcd = 16'h0999;
                b_bcd = 16'h0999;
            end
            if (k == 4) begin
                a_bcd = 16'h0005;
                b_bcd = 16'h0004;
            end
            if (k == 6) check("held_start idle_gap busy", {31'h0, busy}, 0);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) first_k = k;
                if (done_cnt == 2) second_k = k;
                check("held_start sum", {16'h0, sum_bcd}, 32'h0009);
            end
            if (k == 11) start = 1'b0;
        end
        check("held_start done_count", done_cnt, 2);
        check("held_start first_done", first_k, 5);
        check("held_start second_done", second_k, 11);
        $display("held start: %0d done pulses at cycles %0d and %0d", done_cnt, first_k, second_k);

        // asynchronous reset during the second ADD cycle
        @(negedge clk);
        @(negedge clk);
        a_bcd = 16'h4444;
        b_bcd = 16'h5555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort partial_sum", {16'h0, sum_bcd}, 32'h0009);
        rst = 1'b1;
        #1;
        check("abort busy", {31'h0, busy}, 0);
        check("abort done", {31'h0, done}, 0);
        check("abort sum", {16'h0, sum_bcd}, 0);
        check("abort cout", {31'h0, cout}, 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("abort no_done", done_cnt, 0);
        $display("abort: reset mid-add, %0d done pulses afterwards", done_cnt);
        run_add(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, "after_abort_0001_0002");

`ifdef BCD_SERIAL_INPUT_CHECK_EN
        @(negedge clk);
        a_bcd = 16'h12A4;
        b_bcd = 16'h0000;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err set", {31'h0, err}, 1);
        done_k = 0;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
        end
        check("err done_cycle", done_k, 5);
        check("err held_at_done", {31'h0, err}, 1);
        $display("err check: a=12A4 err=%0d done at cycle %0d", err, done_k);
        run_add(16'h0011, 16'h0022, 1'b0, 16'h0033, 1'b0, "err_clear_0011_0022");
        check("err cleared", {31'h0, err}, 0);
`endif

        // single-digit instance
        @(negedge clk);
        a1     = 4'h7;
        b1     = 4'h8;
        cin1   = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("nd1 busy", {31'h0, busy1}, 1);
        done_k = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clk);
            if (done1 === 1'b1) begin
                done_k = k;
                break;
            end
        end
        check("nd1 done_cycle", done_k, 2);
        check("nd1 sum", {28'h0, sum1}, 32'h5);
        check("nd1 cout", {31'h0, cout1}, 1);
        $display("add1 7 + 8 -> sum %h cout %0d", sum1, cout1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
Name: bcd_serial_adder_ctrl

Overview:
- Sequencer that adds two NUM_DIGITS-wide packed-BCD operands, one decimal digit per clock.
- Time-shares a single instance of the existing one-digit decimal adder (Single_Digit_Decimal_Adder) and holds the inter-digit carry in a register.
- Start/busy/done handshake toward the surrounding calculator or display datapath.
- Result is registered and held until the next accepted start.

Parameters:
- NUM_DIGITS, 4, number of BCD digits per operand (legal range 1..8).
- IDX_W, $clog2(NUM_DIGITS) (minimum 1), width of the digit index counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_bcd  input  4*NUM_DIGITS  operand A, digit 0 in bits [3:0]; sampled with accepted start.
- b_bcd  input  4*NUM_DIGITS  operand B, same packing.
- cin  input  1  carry into digit 0; sampled with accepted start.
- busy  output  1  high while digits are being processed (ADD state).
- done  output  1  one-cycle pulse: result valid.
- sum_bcd  output  4*NUM_DIGITS  packed BCD sum, registered.
- cout  output  1  decimal carry out of the most significant digit, registered.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, sum_bcd=0, cout=0, carry=0, idx=0, operand registers=0.
- Reset is asynchronous. Asserting it mid-operation aborts immediately to the reset values; no done pulse is produced.
- States: IDLE, ADD, DONE (encoding from the shared package).
- IDLE, start=1 at an edge: latch a_bcd/b_bcd, carry<=cin, idx<=0, sum_bcd<=0, cout<=0, go ADD.
- IDLE, start=0: hold all outputs, including the previous result.
- ADD: adder inputs are a_reg digit[idx], b_reg digit[idx] and carry (combinational). Each edge writes the adder sum into sum_bcd digit[idx] and sets carry<=adder cout.
  - If idx==NUM_DIGITS-1: cout<=adder cout, go DONE.
  - Otherwise: idx<=idx+1.
- DONE: done=1 for exactly this one cycle, busy=0. Next edge goes to IDLE unconditionally.
- start is ignored in ADD and DONE. It is not queued; the requester must re-assert it in IDLE.
- Latency: start accepted at edge 0 → ADD for edges 1..NUM_DIGITS → done high in the cycle after edge NUM_DIGITS. Back-to-back throughput: one add every NUM_DIGITS+2 cycles.
- busy is a registered decode of state==ADD. done is a registered decode of state==DONE. Neither output is combinational from inputs.
- Partial sum_bcd digits are visible during ADD. They are valid only when done=1 and afterwards until the next accepted start.
- Arithmetic: per digit, the result is in 0..9 with carry 0/1, as defined by the digit adder. With legal inputs the maximum is 9+9+1 = 19, giving digit 9 with carry 1.
- Non-BCD digits (>9) without the optional feature give an undefined sum digit. The FSM still completes normally.
- NUM_DIGITS=1: a single ADD cycle, then DONE.

Optional Feature:
- Macro: BCD_SERIAL_INPUT_CHECK_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - At an accepted start, err<=1 if any digit of a_bcd or b_bcd is >9, else err<=0.
  - err is held until the next accepted start. The add still runs and done still pulses.
- Undefined: no err port and no check logic. The port list is exactly as above.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W=4 and BCD_MAX=4'd9.
  - State typedef/localparams ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - Function extracting digit i from a packed vector.
- Sub-module: Single_Digit_Decimal_Adder, instantiated once (ports a, b, cin, s, cout), unmodified.
- No other sub-modules.

Test Plan:
- NUM_DIGITS=4, a=0x1234, b=0x5678, cin=0, start for one cycle → busy for 4 cycles, done pulse on the 5th cycle after start; sum=0x6912, cout=0.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1 (carry ripples through all digits). Also a=0x9999, b=0x9999, cin=1 → sum=0x9999, cout=1.
- start held high continuously, a=0x0005, b=0x0004 → accepted only in IDLE, one done per NUM_DIGITS+2 cycles. Operand changes while busy do not affect the result (sum=0x0009).
- rst pulsed during the 2nd ADD cycle of 0x4444+0x5555 → all outputs 0 immediately, no done. A subsequent start with 0x0001+0x0002 gives sum=0x0003, cout=0.
- With BCD_SERIAL_INPUT_CHECK_EN: a=0x12A4, b=0x0000 → err=1 from the cycle after start until the next start, done still pulses. Next start with 0x0011+0x0022 → err=0, sum=0x0033.
- NUM_DIGITS=1, a=0x7, b=0x8, cin=0 → done 2 cycles after start, sum=0x5, cout=1.
